decrypt_out_fifo: RTL and testbench
===================================

DECRYPT_OUT_FIFO -- requirements
Module: decrypt_out_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning storage entries; legal values are powers of two from 2 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port din, input, 8 bits: decrypted byte from the XOR/scramble stage (its encrypted_data output).
REQ-005 The block SHALL have port din_valid, input, 1 bit: din qualifier (the XOR stage's encrypted_valid output).
REQ-006 The block SHALL have port mode, input, 1 bit: 1 = decrypt path active; 0 = all writes ignored.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous clear of contents and flags.
REQ-008 The block SHALL have port dout_ready, input, 1 bit: consumer accepts the head byte.
REQ-009 The block SHALL have port dout, output, 8 bits: head byte.
REQ-010 The block SHALL have port dout_valid, output, 1 bit: head byte present.
REQ-011 The block SHALL have port count, output, log2(DEPTH)+1 bits: current occupancy.
REQ-012 The block SHALL have port full, output, 1 bit: count == DEPTH.
REQ-013 The block SHALL have port empty, output, 1 bit: count == 0.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag set when a byte is dropped.

Function
REQ-015 The block SHALL define the write request as din_valid && mode && !flush; the upstream stage has no backpressure.
REQ-016 The block SHALL define the read as dout_valid && dout_ready && !flush.
REQ-017 On a write request with !full, the block SHALL store din at wr_ptr, advance wr_ptr modulo DEPTH, and increase count by 1 unless a read occurs in the same cycle.
REQ-018 On a read, the block SHALL advance rd_ptr modulo DEPTH and decrease count by 1 unless a write occurs in the same cycle.
REQ-019 With full and a simultaneous read, the block SHALL accept the write request; count stays DEPTH and overflow is not set.
REQ-020 With full and no read, the block SHALL drop a write request, leave storage and pointers unchanged, and set overflow to 1 at the next edge.
REQ-021 Overflow SHALL remain 1 until flush or reset.
REQ-022 A written byte SHALL become visible at dout with dout_valid=1 on the cycle after the write edge; there is no combinational bypass from din to dout.
REQ-023 When empty, the block SHALL drive dout_valid=0 and dout=8'h00; a same-cycle write and dout_ready give no read.
REQ-024 When !empty, the block SHALL drive dout from storage at rd_ptr, and dout SHALL stay stable while dout_valid=1 and dout_ready=0.
REQ-025 Bytes SHALL leave the block in arrival order with no duplication or loss, apart from drops under REQ-020.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0 without a bubble cycle.
REQ-027 At the next edge after flush=1, the block SHALL set rd_ptr=wr_ptr=0, count=0, and overflow=0; flush overrides any write or read in that cycle.
REQ-028 When mode is 0, the block SHALL still allow reads, so draining continues while the decrypt path is idle.
REQ-029 The block SHALL derive full, empty and dout_valid combinationally from the registered count.

Reset
REQ-030 While rst=0, regardless of clk, the block SHALL force rd_ptr=0, wr_ptr=0, count=0, overflow=0, dout_valid=0, dout=8'h00, empty=1 and full=0.
REQ-031 Storage contents need not be reset, and no stale entry SHALL ever appear at dout after reset.
REQ-032 Reset asserted mid-operation SHALL discard all held bytes; the first byte written after release SHALL be the first byte read.
REQ-033 Release of rst SHALL take effect at the first clk rising edge after deassertion, with no output glitch.

Verification
REQ-034 Basic: DEPTH=8, mode=1, dout_ready=0, write 8'hA5 then 8'h3C -> count=2, full=0, dout=8'hA5; then dout_ready=1 for 2 cycles -> dout shows 8'h3C, then empty=1 and dout=8'h00.
REQ-035 Overflow: write bytes 1..9 with dout_ready=0 -> full=1 after the 8th write, byte 9 dropped, overflow=1; draining yields 1..8 in order.
REQ-036 Full pass-through: full with dout_ready=1 and a write of 8'hEE -> count stays 8, overflow=0, 8'hEE emerges last.
REQ-037 Wrap and stream: mode=1, dout_ready=1, 20 consecutive bytes -> each byte appears at dout one cycle after its write, count never exceeds 1, and pointers wrap twice.
REQ-038 Flush and mode: with count=5 and overflow=1, pulse flush together with a write -> count=0, overflow=0, empty=1; with mode=0 and din_valid=1 -> count stays 0.
REQ-039 Async reset: with count=4, assert rst low between clock edges -> outputs go to reset values immediately; after release, writing 8'h77 gives dout=8'h77.

Source files
------------

// File: rtl/decrypt_out_fifo.sv
// rtl/decrypt_out_fifo.sv - byte FIFO between the decrypt XOR stage and the downstream consumer
module decrypt_out_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               din,
    input  logic                     din_valid,
    input  logic                     mode,
    input  logic                     flush,
    input  logic                     dout_ready,
    output logic [7:0]               dout,
    output logic                     dout_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_req;
    logic          rd_en;
    logic          wr_en;
    logic          drop;

    assign empty      = (count == '0);
    assign full       = (count == DEPTH_C);
    assign dout_valid = !empty;
    // Masking with empty keeps unreset storage from ever reaching dout.
    assign dout       = empty ? 8'h00 : mem[rd_ptr];

    assign wr_req = din_valid && mode && !flush;
    assign rd_en  = dout_valid && dout_ready && !flush;
    // A read in the same cycle frees a slot, so a full FIFO still accepts.
    assign wr_en  = wr_req && (!full || rd_en);
    assign drop   = wr_req && full && !rd_en;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + (AW + 1)'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - (AW + 1)'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_decrypt_out_fifo.sv
// tb/tb_decrypt_out_fifo.sv - scoreboard bench for decrypt_out_fifo
module tb_decrypt_out_fifo;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       mode = 1'b0;
    logic       flush = 1'b0;
    logic       dout_ready = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    decrypt_out_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .mode(mode),
        .flush(flush), .dout_ready(dout_ready), .dout(dout), .dout_valid(dout_valid),
        .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    logic [7:0] sb[$];
    int n_chk = 0;
    int n_fail = 0;
    int exp_cnt = 0;
    int exp_ovf = 0;
    int model_ovf = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from occupancy alone.
    task automatic cyc(input logic v, input logic [7:0] d, input logic m, input logic f, input logic r);
        int  occ;
        bit  rd;
        @(negedge clk);
        din_valid = v; din = d; mode = m; flush = f; dout_ready = r;
        occ = sb.size();
        exp_cnt = occ;
        exp_ovf = model_ovf;
        rd = (occ > 0) && r && !f;
        if (f) begin
            sb.delete();
            model_ovf = 0;
        end else if (v && m) begin
            if (occ < DEPTH || rd) sb.push_back(d);
            else model_ovf = 1;
        end
    endtask

    initial begin : monitor
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check("count", count, exp_cnt);
                check("dout_valid", dout_valid, exp_cnt > 0);
                check("full", full, exp_cnt == DEPTH);
                check("empty", empty, exp_cnt == 0);
                check("overflow", overflow, exp_ovf);
                if (exp_cnt == 0) check("dout_when_empty", dout, 0);
                if (dout_valid && dout_ready && !flush) begin
                    if (sb.size() == 0) begin
                        check("unexpected_read", 1, 0);
                    end else begin
                        exp_b = sb.pop_front();
                        check("dout_data", dout, exp_b);
                    end
                end
            end
        end
    end

    initial begin
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_overflow", overflow, 0);
        #11;
        rst = 1'b1;
        mon_en = 1'b1;

        // Basic two-byte write and drain
        cyc(1, 8'hA5, 1, 0, 0);
        cyc(1, 8'h3C, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        #1;
        check("basic_count", count, 2);
        check("basic_full", full, 0);
        check("basic_dout", dout, 8'hA5);
        cyc(0, 8'h00, 1, 0, 1);
        cyc(0, 8'h00, 1, 0, 1);
        #1;
        check("basic_dout2", dout, 8'h3C);
        cyc(0, 8'h00, 1, 0, 0);
        #1;
        check("basic_empty", empty, 1);
        check("basic_dout_zero", dout, 0);

        // Overflow: nine writes into eight slots
        for (int i = 1; i <= 9; i++) cyc(1, 8'(i), 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        #1;
        check("ovf_full", full, 1);
        check("ovf_count", count, DEPTH);
        check("ovf_flag", overflow, 1);
        for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0, 1);
        cyc(0, 8'h00, 1, 0, 0);
        #1;
        check("ovf_drained", empty, 1);
        check("ovf_sticky", overflow, 1);

        // Full pass-through
        cyc(0, 8'h00, 1, 1, 0);
        for (int i = 0; i < 8; i++) cyc(1, 8'(8'h10 + i), 1, 0, 0);
        cyc(1, 8'hEE, 1, 0, 1);
        cyc(0, 8'h00, 1, 0, 0);
        #1;
        check("pass_count", count, DEPTH);
        check("pass_ovf", overflow, 0);
        for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1, 0, 1);
        cyc(0, 8'h00, 1, 0, 0);
        #1;
        check("pass_last", dout, 8'hEE);
        cyc(0, 8'h00, 1, 0, 1);

        // Streaming with wrap
        for (int i = 0; i < 20; i++) begin
            cyc(1, 8'(8'h40 + i), 1, 0, 1);
            #1;
            check("stream_count_le1", count <= 1, 1);
            if (i > 0) check("stream_latency", dout, 8'h40 + i - 1);
        end
        cyc(0, 8'h00, 1, 0, 1);
        cyc(0, 8'h00, 1, 0, 0);

        // Flush with write, then mode=0 ignores writes
        for (int i = 0; i < 9; i++) cyc(1, 8'(8'h80 + i), 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0, 1);
        cyc(0, 8'h00, 1, 0, 0);
        #1;
        check("pre_flush_count", count, 5);
        check("pre_flush_ovf", overflow, 1);
        cyc(1, 8'hAA, 1, 1, 0);
        cyc(1, 8'h55, 0, 0, 0);
        cyc(1, 8'h56, 0, 0, 1);
        #1;
        check("flush_count", count, 0);
        check("flush_ovf", overflow, 0);
        check("flush_empty", empty, 1);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'hC0 + i), 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        #1;
        check("prerst_count", count, 4);
        #2;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_dout_valid", dout_valid, 0);
        check("arst_dout", dout, 0);
        check("arst_empty", empty, 1);
        check("arst_full", full, 0);
        check("arst_ovf", overflow, 0);
        sb.delete();
        model_ovf = 0;
        exp_cnt = 0;
        exp_ovf = 0;
        @(negedge clk);
        @(negedge clk);
        #3;
        rst = 1'b1;
        mon_en = 1'b1;
        cyc(1, 8'h77, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        #1;
        check("post_rst_dout", dout, 8'h77);
        check("post_rst_count", count, 1);

        // Randomized traffic with phases biased toward fill or drain
        for (int p = 0; p < 20; p++) begin
            int rdp;
            rdp = $urandom_range(0, 100);
            for (int i = 0; i < 100; i++) begin
                cyc($urandom_range(0, 3) != 0, 8'($urandom),
                    $urandom_range(0, 9) != 0, $urandom_range(0, 79) == 0,
                    $urandom_range(0, 99) < rdp);
            end
        end
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
